// File: rtl/seg7_reader.sv
// seg7_reader: samples an externally multiplexed, active-low 7-segment display
// (segments gfedcba, one digit select low at a time), waits for each digit's
// pattern to hold stable for STABLE_CYCLES synchronized samples, and decodes it
// into a hex nibble per digit.
// Optional feature macro: SEG7_READER_BLANK_EN adds a per-digit 'blank' output
// that reports an all-dark digit (pattern 0x7F) instead of flagging an error.
module seg7_reader #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned NDIG          = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [6:0]        nseg_in,
  input  logic [NDIG-1:0]   ndig_in,
  input  logic              clr,
  output logic [4*NDIG-1:0] value,
  output logic [NDIG-1:0]   valid,
  output logic              frame_done,
`ifdef SEG7_READER_BLANK_EN
  output logic              err,
  output logic [NDIG-1:0]   blank
`else
  output logic              err
`endif
);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  localparam logic [2:0] LAST = 3'(NDIG - 1);

  state_t            state_q, state_d;
  logic [6:0]        seg_s1, seg_s2;
  logic [NDIG-1:0]   dig_s1, dig_s2;
  logic [NDIG+6:0]   prev_q;
  logic [7:0]        cnt_q, cnt_d;
  logic [3:0]        nzero;
  logic [2:0]        idx;
  logic              sel;
  logic              same;
  logic [8:0]        run_len;
  logic              capture;
  logic              dec_ok;
  logic [3:0]        dec_nib;

  // Two-flop synchronizers for the asynchronous pin inputs (idle = all ones).
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_s1 <= '1;
      seg_s2 <= '1;
      dig_s1 <= '1;
      dig_s2 <= '1;
    end else begin
      seg_s1 <= nseg_in;
      seg_s2 <= seg_s1;
      dig_s1 <= ndig_in;
      dig_s2 <= dig_s1;
    end
  end

  // Selection detect: exactly one digit select low; idx is that digit.
  always_comb begin
    nzero = '0;
    idx   = '0;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (!dig_s2[i]) begin
        nzero = nzero + 4'd1;
        idx   = 3'(i);
      end
    end
    sel = (nzero == 4'd1);
  end

  // FSM state, stability counter and previous-sample registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prev_q  <= '1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prev_q  <= {dig_s2, seg_s2};
    end
  end

  // Next-state logic. run_len is the length of the identical-sample run
  // including the current sample; capture fires once when it reaches
  // STABLE_CYCLES, after which HOLD freezes the counter until the sample moves.
  always_comb begin
    same    = (prev_q == {dig_s2, seg_s2});
    run_len = (state_q != IDLE && same) ? ({1'b0, cnt_q} + 9'd1) : 9'd1;
    capture = 1'b0;
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!sel) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (state_q == HOLD && same) begin
      state_d = HOLD;
    end else if (run_len == 9'(STABLE_CYCLES)) begin
      capture = 1'b1;
      state_d = HOLD;
      cnt_d   = run_len[7:0];
    end else begin
      state_d = SETTLE;
      cnt_d   = run_len[7:0];
    end
  end

  // Active-low segment pattern to hex nibble.
  always_comb begin
    dec_ok  = 1'b1;
    dec_nib = '0;
    case (seg_s2)
      7'h40: dec_nib = 4'h0;
      7'h79: dec_nib = 4'h1;
      7'h24: dec_nib = 4'h2;
      7'h30: dec_nib = 4'h3;
      7'h19: dec_nib = 4'h4;
      7'h12: dec_nib = 4'h5;
      7'h02: dec_nib = 4'h6;
      7'h58: dec_nib = 4'h7;
      7'h00: dec_nib = 4'h8;
      7'h10: dec_nib = 4'h9;
      7'h08: dec_nib = 4'hA;
      7'h03: dec_nib = 4'hB;
      7'h46: dec_nib = 4'hC;
      7'h21: dec_nib = 4'hD;
      7'h06: dec_nib = 4'hE;
      7'h0E: dec_nib = 4'hF;
      default: dec_ok = 1'b0;
    endcase
  end

  // Result registers; clr outranks a simultaneous capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      value      <= '0;
      valid      <= '0;
      err        <= 1'b0;
      frame_done <= 1'b0;
`ifdef SEG7_READER_BLANK_EN
      blank      <= '0;
`endif
    end else begin
      frame_done <= capture && (idx == LAST);
      if (clr) begin
        value <= '0;
        valid <= '0;
        err   <= 1'b0;
`ifdef SEG7_READER_BLANK_EN
        blank <= '0;
`endif
      end else if (capture) begin
        for (int unsigned k = 0; k < NDIG; k++) begin
          if (3'(k) == idx) begin
            if (dec_ok) begin
              value[4*k +: 4] <= dec_nib;
              valid[k]        <= 1'b1;
`ifdef SEG7_READER_BLANK_EN
              blank[k]        <= 1'b0;
            end else if (seg_s2 == 7'h7F) begin
              value[4*k +: 4] <= '0;
              valid[k]        <= 1'b0;
              blank[k]        <= 1'b1;
`endif
            end else begin
              valid[k] <= 1'b0;
              err      <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_reader.sv
// Directed bench for seg7_reader (STABLE_CYCLES=4, NDIG=4): table of digit
// captures plus hand sequences for latency, jitter rejection and reset.
module tb_seg7_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  nseg_in;
  logic [3:0]  ndig_in;
  logic        clr;
  logic [15:0] value;
  logic [3:0]  valid;
  logic        frame_done;
  logic        err;
`ifdef SEG7_READER_BLANK_EN
  logic [3:0]  blank;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int fd_count    = 0;

  always #5 clk = ~clk;

  seg7_reader #(.STABLE_CYCLES(4), .NDIG(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .nseg_in    (nseg_in),
    .ndig_in    (ndig_in),
    .clr        (clr),
    .value      (value),
    .valid      (valid),
    .frame_done (frame_done),
`ifdef SEG7_READER_BLANK_EN
    .err        (err),
    .blank      (blank)
`else
    .err        (err)
`endif
  );

  typedef struct {
    logic [3:0]  ndig;
    logic [6:0]  nseg;
    logic        clr;
    int          cycles;
    logic [15:0] exp_value;
    logic [3:0]  exp_valid;
    logic        exp_err;
    int          exp_fd;
    logic [3:0]  exp_blank;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Advance n cycles, sampling 1 time unit after each rising edge.
  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (frame_done === 1'b1) fd_count++;
    end
  endtask

  vec_t tbl[9];

  initial begin
`ifdef SEG7_READER_BLANK_EN
    localparam logic       BLK_ERR = 1'b0;
    localparam logic [15:0] BLK_VAL = 16'h0000;
    localparam logic [3:0]  BLK_B   = 4'b0100;
`else
    localparam logic       BLK_ERR = 1'b1;
    localparam logic [15:0] BLK_VAL = 16'h0100;
    localparam logic [3:0]  BLK_B   = 4'b0000;
`endif
    //           ndig     nseg   clr  cyc  value     valid    err      fd blank
    tbl[0] = '{4'b0111, 7'h0E, 1'b0, 8, 16'hF000, 4'b1000, 1'b0,    1, 4'b0000};
    tbl[1] = '{4'b1011, 7'h46, 1'b0, 8, 16'hFC00, 4'b1100, 1'b0,    0, 4'b0000};
    tbl[2] = '{4'b1101, 7'h03, 1'b0, 8, 16'hFCB0, 4'b1110, 1'b0,    0, 4'b0000};
    tbl[3] = '{4'b1110, 7'h08, 1'b0, 8, 16'hFCBA, 4'b1111, 1'b0,    0, 4'b0000};
    tbl[4] = '{4'b1101, 7'h55, 1'b0, 8, 16'hFCBA, 4'b1101, 1'b1,    0, 4'b0000};
    tbl[5] = '{4'b1111, 7'h7F, 1'b1, 3, 16'h0000, 4'b0000, 1'b0,    0, 4'b0000};
    tbl[6] = '{4'b1011, 7'h79, 1'b0, 8, 16'h0100, 4'b0100, 1'b0,    0, 4'b0000};
    tbl[7] = '{4'b1011, 7'h7F, 1'b0, 8, BLK_VAL,  4'b0000, BLK_ERR, 0, BLK_B};
    tbl[8] = '{4'b1011, 7'h40, 1'b0, 8, 16'h0000, 4'b0100, BLK_ERR, 0, 4'b0000};

    // Reset state
    reset = 1'b1; clr = 1'b0; ndig_in = 4'hF; nseg_in = 7'h7F;
    run(3);
    check("reset_value", 32'(value), 32'h0);
    check("reset_valid", 32'(valid), 32'h0);
    check("reset_err", 32'(err), 32'h0);
    check("reset_fd", 32'(frame_done), 32'h0);
    reset = 1'b0;
    run(2);

    // Single digit latency: visible on the 6th edge after the pin change
    ndig_in = 4'b1110; nseg_in = 7'h24;
    run(5);
    check("lat_before", 32'(valid), 32'h0);
    run(1);
    check("lat_valid", 32'(valid), 32'h1);
    check("lat_value", 32'(value), 32'h0002);
    fd_count = 0;
    run(10);
    check("hold_no_fd", 32'(fd_count), 32'h0);
    ndig_in = 4'hF; nseg_in = 7'h7F;
    run(4);

    // Jitter: pattern changes every 3 cycles, never stable long enough
    ndig_in = 4'b1101;
    for (int t = 0; t < 8; t++) begin
      nseg_in = (t % 2 == 0) ? 7'h24 : 7'h30;
      run(3);
    end
    ndig_in = 4'hF; nseg_in = 7'h7F;
    run(4);
    check("jitter_valid", 32'(valid), 32'h1);
    check("jitter_value", 32'(value), 32'h0002);

    clr = 1'b1; run(1); clr = 1'b0; run(1);
    check("clr_value", 32'(value), 32'h0);
    check("clr_valid", 32'(valid), 32'h0);

    // Table: scan, error digit, clear, blank/undecodable handling
    for (int v = 0; v < 9; v++) begin
      fd_count = 0;
      ndig_in = tbl[v].ndig;
      nseg_in = tbl[v].nseg;
      clr     = tbl[v].clr;
      run(1);
      clr = 1'b0;
      run(tbl[v].cycles - 1);
      check($sformatf("v%0d_value", v), 32'(value), 32'(tbl[v].exp_value));
      check($sformatf("v%0d_valid", v), 32'(valid), 32'(tbl[v].exp_valid));
      check($sformatf("v%0d_err", v), 32'(err), 32'(tbl[v].exp_err));
      check($sformatf("v%0d_fd", v), 32'(fd_count), 32'(tbl[v].exp_fd));
`ifdef SEG7_READER_BLANK_EN
      check($sformatf("v%0d_blank", v), 32'(blank), 32'(tbl[v].exp_blank));
`endif
    end

    // Two digit selects low: never a selection
    ndig_in = 4'hF; nseg_in = 7'h7F;
    clr = 1'b1; run(1); clr = 1'b0; run(3);
    fd_count = 0;
    ndig_in = 4'b1100; nseg_in = 7'h24;
    run(10);
    check("multi_valid", 32'(valid), 32'h0);
    check("multi_value", 32'(value), 32'h0);

    // Reset on the 3rd SETTLE cycle discards the capture
    ndig_in = 4'b1110; nseg_in = 7'h30;
    run(5);
    reset = 1'b1;
    run(1);
    reset = 1'b0;
    check("rst_mid_valid", 32'(valid), 32'h0);
    run(5);
    check("rst_fresh_wait", 32'(valid), 32'h0);
    run(1);
    check("rst_fresh_valid", 32'(valid), 32'h1);
    check("rst_fresh_value", 32'(value), 32'h0003);
    check("rst_fd", 32'(fd_count), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
